// File: rtl/gfx_sp_fetch.sv
// Shader-processor operand fetch: scoreboard hazard check, two register-file
// reads with a fixed 3-cycle return latency, and a held output handshake.
package gfx_defs;
    typedef logic [3:0]   vreg_num;
    typedef logic [127:0] vec4;
endpackage

module gfx_sp_fetch
    import gfx_defs::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    output logic    in_ready,
    input  vreg_num in_src_a,
    input  vreg_num in_src_b,
    input  vreg_num in_dst,
    input  logic    in_dst_wr,
    output vreg_num rd_reg,
    input  vec4     rd_data,
    input  logic    wb_valid,
    input  vreg_num wb_reg,
    output logic    out_valid,
    input  logic    out_ready,
    output vec4     out_a,
    output vec4     out_b,
    output vreg_num out_dst,
    output logic    out_dst_wr
);
    localparam int NREG = 1 << $bits(vreg_num);

    typedef enum logic [1:0] {IDLE, CHECK, READ, OUT} state_t;

    state_t          state;
    vreg_num         src_a_q;
    vreg_num         src_b_q;
    vreg_num         dst_q;
    logic            dst_wr_q;
    logic [2:0]      cnt;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_set;
    logic [NREG-1:0] pend_clr;
    logic            hazard;
    logic            out_hs;

    assign hazard   = pending[src_a_q] | pending[src_b_q] | (dst_wr_q & pending[dst_q]);
    assign out_hs   = out_valid & out_ready;
    assign in_ready = rst_n & (state == IDLE);

    // Reads must leave in the same cycle the hazard clears, so the index is decoded
    // from current state rather than registered.
    always_comb begin
        rd_reg = '0;
        if (state == CHECK && !hazard)
            rd_reg = src_a_q;
        else if (state == READ && cnt == 3'd0)
            rd_reg = src_b_q;
    end

    // A destination claimed on the handshake outranks a writeback in the same cycle.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (wb_valid)
            pend_clr[wb_reg] = 1'b1;
        if (out_hs && out_dst_wr)
            pend_set[out_dst] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            src_a_q    <= '0;
            src_b_q    <= '0;
            dst_q      <= '0;
            dst_wr_q   <= 1'b0;
            cnt        <= '0;
            pending    <= '0;
            out_valid  <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_dst    <= '0;
            out_dst_wr <= 1'b0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src_a_q  <= in_src_a;
                        src_b_q  <= in_src_b;
                        dst_q    <= in_dst;
                        dst_wr_q <= in_dst_wr;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (!hazard) begin
                        cnt   <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    // cnt 0 is the src_b issue cycle; src_a data lands at 2, src_b at 3
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd2)
                        out_a <= rd_data;
                    if (cnt == 3'd3) begin
                        out_b      <= rd_data;
                        out_dst    <= dst_q;
                        out_dst_wr <= dst_wr_q;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gfx_sp_fetch.sv
// Self-checking bench for gfx_sp_fetch: behavioural register file with 3-cycle
// read latency and a pending-register model driving expected timing and data.
module tb_gfx_sp_fetch;
    import gfx_defs::*;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    in_valid;
    logic    in_ready;
    vreg_num in_src_a, in_src_b, in_dst;
    logic    in_dst_wr;
    vreg_num rd_reg;
    vec4     rd_data;
    logic    wb_valid;
    vreg_num wb_reg;
    vec4     wb_data;
    logic    out_valid;
    logic    out_ready;
    vec4     out_a, out_b;
    vreg_num out_dst;
    logic    out_dst_wr;

    int errors = 0;
    int checks = 0;
    logic [15:0] pend_m = '0;

    vec4 rf [16];
    vec4 rd_pipe [3];

    gfx_sp_fetch dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dst(in_dst), .in_dst_wr(in_dst_wr),
        .rd_reg(rd_reg), .rd_data(rd_data), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_dst(out_dst), .out_dst_wr(out_dst_wr)
    );

    always #5 clk = ~clk;

    // Register file: index at cycle t returns at t+3; writes visible from the next cycle.
    always @(posedge clk) begin
        rd_pipe[0] <= rf[rd_reg];
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
        if (wb_valid) rf[wb_reg] <= wb_data;
    end
    assign rd_data = rd_pipe[2];

    task automatic cyc();
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic smp();
        #4;
    endtask

    task automatic wb(input vreg_num r);
        wb_valid  = 1'b1;
        wb_reg    = r;
        wb_data   = {$urandom, $urandom, $urandom, $urandom};
        pend_m[r] = 1'b0;
    endtask

    task automatic bg();
        vreg_num cand[$];
        if ($urandom_range(0, 3) != 0) return;
        for (int i = 0; i < 16; i++) if (pend_m[i]) cand.push_back(vreg_num'(i));
        if (cand.size() > 0) wb(cand[$urandom_range(0, cand.size() - 1)]);
    endtask

    task automatic drain();
        for (int i = 0; i < 16; i++) begin
            if (pend_m[i]) begin
                cyc();
                wb(vreg_num'(i));
            end
        end
    endtask

    task automatic do_instr(input vreg_num sa, input vreg_num sb, input vreg_num d,
                            input logic dw, input int bp, input int hs_wb, input bit rand_wb);
        vec4 ea, eb;
        vreg_num r;
        int n;
        cyc();
        in_valid = 1'b1; in_src_a = sa; in_src_b = sb; in_dst = d; in_dst_wr = dw;
        smp();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b want 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        n = 0;
        while ((pend_m[sa] | pend_m[sb] | (dw & pend_m[d])) && n < 60) begin
            if ($urandom_range(0, 1) == 1) begin
                if (pend_m[sa]) r = sa; else if (pend_m[sb]) r = sb; else r = d;
                wb(r);
            end
            smp();
            checks++; if (rd_reg !== '0) begin errors++; $display("FAIL stall_rd_reg: got %0d want 0", rd_reg); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
            cyc();
            n++;
        end
        if (rand_wb) bg();
        smp();
        checks++; if (rd_reg !== sa) begin errors++; $display("FAIL issue_a: rd_reg got %0d want %0d", rd_reg, sa); end
        ea = rf[sa];
        cyc();
        if (rand_wb) bg();
        smp();
        checks++; if (rd_reg !== sb) begin errors++; $display("FAIL issue_b: rd_reg got %0d want %0d", rd_reg, sb); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b want 0", out_valid); end
        eb = rf[sb];
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (rand_wb) bg();
            smp();
            checks++; if (rd_reg !== '0) begin errors++; $display("FAIL idle_rd_reg: got %0d want 0", rd_reg); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b want 0", out_valid); end
        end
        for (int i = 0; i <= bp; i++) begin
            cyc();
            out_ready = (i == bp);
            if (i == bp && hs_wb >= 0) wb(vreg_num'(hs_wb));
            else if (rand_wb) bg();
            smp();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL out_valid: got %b want 1", out_valid); end
            checks++; if (out_a !== ea) begin errors++; $display("FAIL out_a: got %h want %h", out_a, ea); end
            checks++; if (out_b !== eb) begin errors++; $display("FAIL out_b: got %h want %h", out_b, eb); end
            checks++; if (out_dst !== d || out_dst_wr !== dw) begin
                errors++; $display("FAIL out_dst: got %0d/%b want %0d/%b", out_dst, out_dst_wr, d, dw);
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready: got %b want 0", in_ready); end
        end
        if (dw) pend_m[d] = 1'b1;
        cyc();
        out_ready = 1'b0;
        smp();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL post_handshake: out_valid %b in_ready %b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_src_a = '0; in_src_b = '0; in_dst = '0; in_dst_wr = 1'b0;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b0;
        repeat (3) cyc();
        smp();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0 || out_dst_wr !== 1'b0 || rd_reg !== '0) begin
            errors++; $display("FAIL reset_outs: valid %b dst_wr %b rd_reg %0d want 0", out_valid, out_dst_wr, rd_reg);
        end
        checks++; if (out_a !== '0 || out_b !== '0 || out_dst !== '0) begin
            errors++; $display("FAIL reset_data: a %h b %h dst %0d want 0", out_a, out_b, out_dst);
        end
        cyc();
        rst_n = 1'b1;
        smp();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        // Writebacks to non-pending registers preload the file and must be no-ops.
        for (int i = 0; i < 16; i++) begin
            cyc();
            wb(vreg_num'(i));
        end
        cyc();
    endtask

    task automatic reset_during(input int at, input vreg_num d);
        drain();
        cyc();
        in_valid = 1'b1; in_src_a = 4'd1; in_src_b = 4'd2; in_dst = d; in_dst_wr = 1'b1;
        smp();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_accept: got %b want 1", in_ready); end
        for (int c = 1; c <= at; c++) begin
            cyc();
            in_valid = 1'b0;
            if (c == at) rst_n = 1'b0;
            smp();
            if (c == 6) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_in_out: got %b want 1", out_valid); end
            end
            if (c == at) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_low_in_ready: got %b want 0", in_ready); end
            end
        end
        cyc();
        rst_n = 1'b1;
        pend_m = '0;
        smp();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_after_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0 || rd_reg !== '0 || out_dst_wr !== 1'b0 || out_a !== '0) begin
            errors++; $display("FAIL rst_after_outs: valid %b rd %0d dst_wr %b a %h", out_valid, rd_reg, out_dst_wr, out_a);
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            smp();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ghost_valid: got %b want 0", out_valid); end
        end
        do_instr(d, d, d, 1'b1, 0, -1, 1'b0);
    endtask

    task automatic test_no_hazard();
        do_instr(4'd1, 4'd2, 4'd3, 1'b1, 0, -1, 1'b0);
    endtask

    task automatic test_raw_stall();
        do_instr(4'd3, 4'd4, 4'd6, 1'b1, 0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_instr(4'd7, 4'd8, 4'd9, 1'b0, 10, -1, 1'b0);
        do_instr(4'd7, 4'd7, 4'd10, 1'b0, 0, -1, 1'b0);
    endtask

    task automatic test_same_cycle();
        drain();
        do_instr(4'd1, 4'd2, 4'd5, 1'b1, 0, 5, 1'b0);
        do_instr(4'd5, 4'd1, 4'd11, 1'b0, 0, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_instr(4'd1, 4'd2, 4'd12, 1'b1, 0, -1, 1'b0);
        reset_during(3, 4'd12);
        do_instr(4'd2, 4'd3, 4'd13, 1'b1, 1, -1, 1'b0);
        reset_during(7, 4'd13);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_instr(vreg_num'($urandom_range(0, 15)), vreg_num'($urandom_range(0, 15)),
                     vreg_num'($urandom_range(0, 15)), logic'($urandom_range(0, 1)),
                     $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_raw_stall();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
